reg_bank_32x32: RTL and testbench
=================================

Name: reg_bank_32x32

Overview:
- 32-entry x 32-bit architectural register bank. Its 32-word output array drives the data inputs of the downstream 32:1 x 32-bit read multiplexer, which performs register read selection.
- Provides one write-back port with a valid/ready handshake and per-byte write enables.
- Register 0 can be hardwired to zero.
- A sequential bulk-clear engine walks all 32 entries, one per cycle, for context reset without asserting global reset.

Parameters:
- CLEAR_VAL, 32'h0000_0000, value written into each entry by the bulk-clear engine.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes and clears; 0 = entry 0 is an ordinary register.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  bank can accept a write this cycle.
- wr_addr  input  5  destination entry 0..31.
- wr_data  input  32  write data.
- wr_be  input  4  byte enables; bit k enables wr_data[8k+7:8k].
- clr_req  input  1  single-cycle pulse; starts a bulk clear.
- clr_busy  output  1  bulk clear in progress.
- regs  output  32 x 32 (unpacked [0:31])  current contents of all entries, connected directly to the mux data inputs.
- written  output  32  bit i = entry i written since the last reset or clear.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All regs entries = 32'h0 (not CLEAR_VAL).
  - written = 0, clr_busy = 0, FSM = IDLE, clear index = 0.
  - wr_ready = 0 while rst_n is low.
- FSM states: IDLE and CLEAR.
- IDLE:
  - wr_ready = !clr_req (combinational).
  - A write is accepted when wr_valid && wr_ready are both high at a rising edge.
  - The addressed entry updates only in the enabled bytes; other bytes hold.
  - written[wr_addr] is set if wr_be != 0.
- Write latency: the new value is visible on regs in the cycle after the accepting edge. The bank has no internal bypass; forwarding is the pipeline's responsibility.
- wr_be = 0 with wr_valid: handshake completes, data and written are unchanged.
- ZERO_REG = 1: a write to entry 0 is accepted (handshake completes), regs[0] stays 0 and written[0] stays 0.
- IDLE -> CLEAR: on an edge where clr_req = 1.
  - clr_req has priority over a simultaneous wr_valid; that write is not accepted and must be held by the producer.
  - Clear index set to 0, clr_busy = 1 from the next cycle.
- CLEAR:
  - wr_ready = 0 and clr_busy = 1.
  - Each edge: regs[index] = CLEAR_VAL, written[index] = 0, index increments.
  - With ZERO_REG = 1, index 0 is skipped in effect: it stays 0.
  - clr_req is ignored while in CLEAR.
- CLEAR -> IDLE: on the edge that clears index 31.
  - clr_busy is high for exactly 32 cycles.
  - wr_ready can return high in the first IDLE cycle.
- The clear index is a 5-bit counter; leaving CLEAR at 31 is explicit and does not depend on wrap-around.
- Reset asserted mid-clear: immediate return to the reset state above; the clear is not resumed.
- No X on any output after reset; undefined wr_addr is impossible because all 5-bit values are valid.

Test Plan:
- Reset, then write entry 5 = 32'hDEAD_BEEF with wr_be = 4'hF -> next cycle regs[5] = DEADBEEF, written = 32'h0000_0020, all other entries 0.
- Entry 7 holds 32'h1122_3344; write 32'hAABB_CCDD with wr_be = 4'b0101 -> regs[7] = 32'h11BB_33DD.
- ZERO_REG = 1: write 32'hFFFF_FFFF to entry 0 -> handshake completes, regs[0] = 0, written[0] = 0.
- CLEAR_VAL = 32'h5A5A_5A5A, all entries written; pulse clr_req together with wr_valid to entry 3 ->
  - wr_ready = 0 that cycle and the write is not accepted.
  - clr_busy high for 32 cycles; regs[1..31] = 5A5A5A5A and regs[0] = 0.
  - written = 0; wr_ready high in the cycle after clr_busy falls.
- Pulse clr_req again at cycle 10 of a clear -> completion still at cycle 32; no restart.
- Assert rst_n low at cycle 16 of a clear -> all entries 0, clr_busy = 0, wr_ready = 0 during reset and 1 after release.

Source files
------------

// File: rtl/reg_bank_32x32.sv
// rtl/reg_bank_32x32.sv - 32x32 register bank with byte-enabled write port and bulk-clear engine
module reg_bank_32x32 #(
  parameter logic [31:0] CLEAR_VAL = 32'h0000_0000,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic [31:0] regs [0:31],
  output logic [31:0] written
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic [4:0] idx;
  logic       wr_accept;
  logic       wr_blocked;

  // clr_req wins over a same-cycle write, so it also gates the handshake
  assign wr_ready   = rst_n && (state == IDLE) && !clr_req;
  assign wr_accept  = wr_valid && wr_ready;
  assign wr_blocked = ZERO_REG && (wr_addr == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 5'd0;
      clr_busy <= 1'b0;
      written  <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state    <= CLEAR;
        idx      <= 5'd0;
        clr_busy <= 1'b1;
      end else if (wr_accept && (wr_be != 4'd0) && !wr_blocked) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        written[wr_addr] <= 1'b1;
      end
    end else begin
      if (!(ZERO_REG && (idx == 5'd0))) regs[idx] <= CLEAR_VAL;
      written[idx] <= 1'b0;
      // exit is decoded from index 31 rather than relying on counter wrap
      if (idx == 5'd31) begin
        state    <= IDLE;
        clr_busy <= 1'b0;
      end else begin
        idx <= idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// tb/tb_reg_bank_32x32.sv - directed scoreboard bench for reg_bank_32x32
module tb_reg_bank_32x32;

  localparam logic [31:0] CV = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clr_req;
  logic        clr_busy;
  logic [31:0] regs [0:31];
  logic [31:0] written;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_written;
  int          tests = 0;
  int          fails = 0;
  int          n;

  reg_bank_32x32 #(.CLEAR_VAL(CV), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req),
    .clr_busy(clr_busy), .regs(regs), .written(written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_written = 32'h0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: m_regs[i]});
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("%s_regs[%0d]", tag, e.addr), regs[e.addr], e.data);
    end
    chk({tag, "_written"}, written, m_written);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    #1;
    chk($sformatf("wr_ready_addr%0d", a), {31'h0, wr_ready}, 32'h1);
    if (a != 5'd0) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_regs[a][8*b +: 8] = d[8*b +: 8];
      if (be != 4'd0) m_written[a] = 1'b1;
    end
    sb.push_back('{addr: a, data: m_regs[a]});
    step();
    wr_valid = 1'b0;
    e = sb.pop_front();
    chk($sformatf("wr_regs[%0d]", e.addr), regs[e.addr], e.data);
    chk($sformatf("wr_written_addr%0d", a), written, m_written);
  endtask

  task automatic clear_model();
    for (int i = 1; i < 32; i++) m_regs[i] = CV;
    m_written = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; wr_be = 4'h0; clr_req = 1'b0;
    model_reset();
    #2;
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_clr_busy", {31'h0, clr_busy}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    check_all("reset");

    do_write(5'd5, 32'hDEAD_BEEF, 4'hF);
    chk("tp1_written", written, 32'h0000_0020);
    check_all("tp1");

    do_write(5'd7, 32'h1122_3344, 4'hF);
    do_write(5'd7, 32'hAABB_CCDD, 4'b0101);
    chk("tp2_merge", regs[7], 32'h11BB_33DD);

    do_write(5'd0, 32'hFFFF_FFFF, 4'hF);
    chk("zero_reg", regs[0], 32'h0);
    chk("zero_written0", {31'h0, written[0]}, 32'h0);

    do_write(5'd9, 32'hCAFE_F00D, 4'h0);
    chk("be0_regs9", regs[9], 32'h0);

    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom, 4'hF);
    check_all("fill");

    // clear collides with a write to entry 3
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0BAD_0BAD; wr_be = 4'hF;
    #1;
    chk("clr_wr_ready", {31'h0, wr_ready}, 32'h0);
    step();
    clr_req = 1'b0; wr_valid = 1'b0;
    chk("clr_no_write3", regs[3], m_regs[3]);
    n = 0;
    while (clr_busy && n < 40) begin n++; step(); end
    chk("clr_busy_cycles", n, 32);
    chk("clr_ready_after", {31'h0, wr_ready}, 32'h1);
    clear_model();
    check_all("clr1");

    do_write(5'd12, 32'h0102_0304, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 40) begin
      n++;
      clr_req = (n == 10);
      step();
    end
    clr_req = 1'b0;
    chk("clr2_busy_cycles", n, 32);
    step(); step();
    chk("clr2_no_restart", {31'h0, clr_busy}, 32'h0);
    clear_model();
    check_all("clr2");

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 16) begin n++; step(); end
    chk("clr3_reached16", n, 16);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", {31'h0, clr_busy}, 32'h0);
    chk("midrst_ready", {31'h0, wr_ready}, 32'h0);
    check_all("midrst");
    step();
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", {31'h0, wr_ready}, 32'h1);
    step(); step();
    chk("postrst_busy", {31'h0, clr_busy}, 32'h0);
    check_all("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
